// File: rtl/io_uart_responder_pkg.sv
// Shared types and constants for the io_uart_responder slice: bus direction codes,
// UART frame width and the FSM state encodings used by the TX, RX and bus machines.
package io_uart_responder_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    // One encoding serves both serial machines; both walk the same four frame phases
    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE    = 2'd0,
        BUS_WAIT_TX = 2'd1,
        BUS_WAIT_RX = 2'd2,
        BUS_ACK     = 2'd3
    } bus_state_t;

endpackage

// File: rtl/io_uart_responder_if.sv
// CPU io_req/io_ack port as seen by the UART responder; the CPU side is the master.
interface io_uart_responder_if;
    import io_uart_responder_pkg::*;

    logic                      io_req;
    logic                      io_dir;
    logic [UART_DATA_BITS-1:0] io_wdata;
    logic                      io_ack;
    logic [UART_DATA_BITS-1:0] io_rdata;

    modport master (
        output io_req, io_dir, io_wdata,
        input  io_ack, io_rdata
    );

    modport slave (
        input  io_req, io_dir, io_wdata,
        output io_ack, io_rdata
    );

endinterface

// File: rtl/io_uart_responder_rx_deser.sv
// 8N1 receive deserialiser: synchronises uart_rx, finds start edges, samples bit centres
// and reports each frame as a one-cycle valid or frame-error pulse.
module uart_rx_deser
    import io_uart_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_rx,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      rx_valid,
    output logic                      rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      rx_meta;
    logic                      rx_sync;
    logic                      rx_prev;
    uart_state_t               state, state_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [2:0]                bit_idx, bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift, shift_next;
    logic                      stop_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            state   <= U_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // The start half-bit re-check both rejects glitches and aligns later samples to bit centres
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        case (state)
            U_IDLE: begin
                cnt_next = '0;
                if (rx_prev && !rx_sync) state_next = U_START;
            end
            U_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_sync, shift[UART_DATA_BITS-1:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) state_next = U_STOP;
                end
            end
            U_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = U_IDLE;
                end
            end
            default: state_next = U_IDLE;
        endcase
    end

    always_comb begin
        stop_tick    = (state == U_STOP) && (cnt == BIT_LAST);
        rx_valid     = stop_tick && rx_sync;
        rx_frame_err = stop_tick && !rx_sync;
        rx_byte      = shift;
    end

endmodule

// File: rtl/io_uart_responder.sv
// CPU IO responder: writes go out on an 8N1 UART transmitter, reads pop a small RX FIFO
// fed by uart_rx_deser, stalling the CPU until data is available.
module io_uart_responder
    import io_uart_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50,
    parameter int RX_FIFO_AW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    io_uart_responder_if.slave  io,
    output logic                uart_tx,
    input  logic                uart_rx,
    output logic                rx_overrun,
    output logic                rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << RX_FIFO_AW;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t               tx_state, tx_state_next;
    logic [CNT_W-1:0]          tx_cnt, tx_cnt_next;
    logic [2:0]                tx_bit_idx, tx_bit_idx_next;
    logic [UART_DATA_BITS-1:0] tx_shift, tx_shift_next;
    logic                      tx_bit_end;
    logic                      tx_ready;
    logic                      tx_load;

    logic [UART_DATA_BITS-1:0] fifo_mem [DEPTH];
    logic [RX_FIFO_AW:0]       wr_ptr, rd_ptr;
    logic                      fifo_empty, fifo_full, fifo_pop, fifo_push;
    logic [UART_DATA_BITS-1:0] fifo_head;

    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      rx_valid;
    logic                      rx_ferr;

    bus_state_t                bus_state, bus_state_next;
    logic                      ack_seen;
    logic                      bus_accept;

    uart_rx_deser #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_deser (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_ferr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= U_IDLE;
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shift   <= '0;
        end else begin
            tx_state   <= tx_state_next;
            tx_cnt     <= tx_cnt_next;
            tx_bit_idx <= tx_bit_idx_next;
            tx_shift   <= tx_shift_next;
        end
    end

    // A load takes priority in any state; the bus only loads when tx_ready, so frames abut
    always_comb begin
        tx_state_next   = tx_state;
        tx_cnt_next     = tx_cnt + 1'b1;
        tx_bit_idx_next = tx_bit_idx;
        tx_shift_next   = tx_shift;
        if (tx_load) begin
            tx_state_next   = U_START;
            tx_cnt_next     = '0;
            tx_bit_idx_next = '0;
            tx_shift_next   = io.io_wdata;
        end else begin
            case (tx_state)
                U_IDLE: tx_cnt_next = '0;
                U_START: begin
                    if (tx_bit_end) begin
                        tx_cnt_next   = '0;
                        tx_state_next = U_DATA;
                    end
                end
                U_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt_next     = '0;
                        tx_shift_next   = tx_shift >> 1;
                        tx_bit_idx_next = tx_bit_idx + 1'b1;
                        if (tx_bit_idx == LAST_BIT) tx_state_next = U_STOP;
                    end
                end
                U_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt_next   = '0;
                        tx_state_next = U_IDLE;
                    end
                end
                default: tx_state_next = U_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_bit_end = (tx_cnt == BIT_LAST);
        tx_ready   = (tx_state == U_IDLE) || ((tx_state == U_STOP) && tx_bit_end);
        case (tx_state)
            U_START: uart_tx = 1'b0;
            U_DATA:  uart_tx = tx_shift[0];
            default: uart_tx = 1'b1;
        endcase
    end

    // A push while full is still accepted when a pop frees the slot in the same cycle
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[RX_FIFO_AW] != rd_ptr[RX_FIFO_AW]) &&
                     (wr_ptr[RX_FIFO_AW-1:0] == rd_ptr[RX_FIFO_AW-1:0]);
        fifo_push  = rx_valid && (!fifo_full || fifo_pop);
        fifo_head  = fifo_mem[rd_ptr[RX_FIFO_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[RX_FIFO_AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            rx_overrun   <= rx_valid && fifo_full && !fifo_pop;
            rx_frame_err <= rx_ferr;
        end
    end

    // ack_seen masks io_req for the cycle after ACK, while the initiator is still dropping it
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state   <= BUS_IDLE;
            ack_seen    <= 1'b0;
            io.io_rdata <= '0;
        end else begin
            bus_state <= bus_state_next;
            ack_seen  <= (bus_state == BUS_ACK);
            if (fifo_pop) io.io_rdata <= fifo_head;
        end
    end

    always_comb begin
        bus_state_next = bus_state;
        case (bus_state)
            BUS_IDLE: begin
                if (bus_accept) begin
                    if (io.io_dir == DIR_WRITE) bus_state_next = tx_ready ? BUS_ACK : BUS_WAIT_TX;
                    else                        bus_state_next = fifo_empty ? BUS_WAIT_RX : BUS_ACK;
                end
            end
            BUS_WAIT_TX: if (tx_ready)    bus_state_next = BUS_ACK;
            BUS_WAIT_RX: if (!fifo_empty) bus_state_next = BUS_ACK;
            BUS_ACK:     bus_state_next = BUS_IDLE;
            default:     bus_state_next = BUS_IDLE;
        endcase
    end

    always_comb begin
        bus_accept = (bus_state == BUS_IDLE) && io.io_req && !ack_seen;
        tx_load    = (bus_accept && (io.io_dir == DIR_WRITE) && tx_ready) ||
                     ((bus_state == BUS_WAIT_TX) && tx_ready);
        fifo_pop   = (bus_accept && (io.io_dir == DIR_READ) && !fifo_empty) ||
                     ((bus_state == BUS_WAIT_RX) && !fifo_empty);
        io.io_ack  = (bus_state == BUS_ACK);
    end

endmodule

// File: tb/tb_io_uart_responder.sv
// Randomised scoreboard bench for io_uart_responder: a queue-based model predicts acks,
// read data, transmitted frames and RX error pulses; monitors decode and compare.
module tb_io_uart_responder;
    import io_uart_responder_pkg::*;

    localparam int CPB        = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        bit         is_read;
        logic [7:0] data;
    } ack_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx;
    logic uart_rx = 1'b1;
    logic rx_overrun;
    logic rx_frame_err;

    io_uart_responder_if ifc ();

    io_uart_responder #(
        .CLKS_PER_BIT (CPB),
        .RX_FIFO_AW   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .io           (ifc),
        .uart_tx      (uart_tx),
        .uart_rx      (uart_rx),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ack_exp_t   exp_ack[$];
    logic [7:0] exp_tx[$];
    logic [7:0] model_q[$];
    int         tx_starts[$];
    int         pending_reads = 0;
    int         exp_ovr  = 0;
    int         exp_ferr = 0;
    int         ovr_seen  = 0;
    int         ferr_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Reference model: byte-order queues, no notion of the DUT's timing or encodings
    function automatic void model_write(input logic [7:0] b);
        ack_exp_t e;
        e.is_read = 1'b0;
        e.data    = b;
        exp_ack.push_back(e);
        exp_tx.push_back(b);
    endfunction

    function automatic void model_read();
        ack_exp_t e;
        if (model_q.size() > 0) begin
            e.is_read = 1'b1;
            e.data    = model_q.pop_front();
            exp_ack.push_back(e);
        end else begin
            pending_reads++;
        end
    endfunction

    function automatic void model_rx(input logic [7:0] b);
        ack_exp_t e;
        if (pending_reads > 0) begin
            pending_reads--;
            e.is_read = 1'b1;
            e.data    = b;
            exp_ack.push_back(e);
        end else if (model_q.size() < FIFO_DEPTH) begin
            model_q.push_back(b);
        end else begin
            exp_ovr++;
        end
    endfunction

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        ifc.io_req = 1'b0;
        uart_rx    = 1'b1;
        exp_ack.delete();
        exp_tx.delete();
        model_q.delete();
        pending_reads = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input logic dir, input logic [7:0] wd, input int budget,
                                  output logic got, output int ack_cyc);
        int waited;
        @(posedge clk);
        #1;
        if (dir == DIR_WRITE) model_write(wd);
        else                  model_read();
        ifc.io_req   = 1'b1;
        ifc.io_dir   = dir;
        ifc.io_wdata = wd;
        got     = 1'b0;
        ack_cyc = -1;
        waited  = 0;
        while (!got && waited < budget) begin
            @(negedge clk);
            waited++;
            if (ifc.io_ack) begin
                got     = 1'b1;
                ack_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        ifc.io_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val, output int stop_cyc);
        if (stop_val) model_rx(b);
        else          exp_ferr++;
        stop_cyc = -1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      uart_rx = 1'b0;
            else if (i == 9) uart_rx = stop_val;
            else             uart_rx = b[i-1];
            if (i == 9) stop_cyc = cyc;
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic mon_wait(input int n, inout logic aborted);
        repeat (n) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
        end
    endtask

    // Ack scoreboard: every io_ack must match the oldest predicted completion
    always @(negedge clk) begin
        ack_exp_t e;
        if (ifc.io_ack) begin
            if (exp_ack.size() == 0) begin
                check_output("unexpected_ack", 1, 0);
            end else begin
                e = exp_ack.pop_front();
                if (e.is_read) check_output("read_data", int'(ifc.io_rdata), int'(e.data));
            end
        end
        if (rx_overrun)   ovr_seen++;
        if (rx_frame_err) ferr_seen++;
    end

    // TX monitor: an independent 8N1 receiver on uart_tx sampling bit centres
    initial begin : tx_monitor
        logic [7:0] b;
        logic       aborted;
        logic       start_ok;
        logic       stop_ok;
        int         start_cyc;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx == 1'b0) begin
                start_cyc = cyc;
                aborted   = 1'b0;
                mon_wait(CPB / 2, aborted);
                start_ok = (uart_tx == 1'b0);
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB, aborted);
                    b[i] = uart_tx;
                end
                mon_wait(CPB, aborted);
                stop_ok = uart_tx;
                if (!aborted) begin
                    tx_starts.push_back(start_cyc);
                    check_output("tx_start_bit", int'(start_ok), 1);
                    check_output("tx_stop_bit", int'(stop_ok), 1);
                    if (exp_tx.size() == 0) check_output("unexpected_tx_frame", int'(b), -1);
                    else                    check_output("tx_byte", int'(b), int'(exp_tx.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic       got;
        int         ack_cyc, ack_a, stop_cyc, mism;
        logic [7:0] b;
        logic       wave [80];

        ifc.io_req   = 1'b0;
        ifc.io_dir   = DIR_READ;
        ifc.io_wdata = '0;
        apply_reset();

        @(negedge clk);
        check_output("reset_io_ack", int'(ifc.io_ack), 0);
        check_output("reset_io_rdata", int'(ifc.io_rdata), 0);
        check_output("reset_uart_tx", int'(uart_tx), 1);
        check_output("reset_rx_overrun", int'(rx_overrun), 0);
        check_output("reset_rx_frame_err", int'(rx_frame_err), 0);

        // Write 0x41 with TX idle: ack in cycle N+1, exact waveform from that cycle
        @(posedge clk);
        #1;
        model_write(8'h41);
        ifc.io_req   = 1'b1;
        ifc.io_dir   = DIR_WRITE;
        ifc.io_wdata = 8'h41;
        @(negedge clk);
        check_output("ack_cycle_n", int'(ifc.io_ack), 0);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_output("ack_cycle_n_plus_1", int'(ifc.io_ack), 1);
                ifc.io_req = 1'b0;
            end
            if (i == 1) check_output("ack_single_cycle", int'(ifc.io_ack), 0);
            wave[i] = uart_tx;
        end
        b    = 8'h41;
        mism = 0;
        for (int i = 0; i < 80; i++) begin
            if (i < 8)       mism += (wave[i] != 1'b0) ? 1 : 0;
            else if (i < 72) mism += (wave[i] != b[(i-8)/8]) ? 1 : 0;
            else             mism += (wave[i] != 1'b1) ? 1 : 0;
        end
        check_output("tx_wave_0x41_bad_cycles", mism, 0);
        repeat (10) @(negedge clk);

        // Back-to-back writes: second ack when the second start bit begins
        tx_starts.delete();
        apply_stimulus(DIR_WRITE, 8'h55, 20, got, ack_a);
        check_output("b2b_first_ack", int'(got), 1);
        apply_stimulus(DIR_WRITE, 8'hAA, 200, got, ack_cyc);
        check_output("b2b_second_ack", int'(got), 1);
        check_output("b2b_second_ack_cycle", ack_cyc - ack_a, 10 * CPB);
        repeat (10 * CPB + 10) @(negedge clk);
        if (tx_starts.size() == 2) check_output("b2b_frame_gap", tx_starts[1] - tx_starts[0], 10 * CPB);
        else                       check_output("b2b_frame_count", tx_starts.size(), 2);

        // Read with FIFO empty: stalls until 0x3C has been received
        fork
            apply_stimulus(DIR_READ, 8'h00, 400, got, ack_cyc);
            begin
                repeat (20) @(negedge clk);
                send_byte(8'h3C, 1'b1, stop_cyc);
            end
        join
        check_output("blocked_read_acked", int'(got), 1);
        check_output("blocked_read_after_stop_centre", int'(ack_cyc > stop_cyc + CPB / 2), 1);
        check_output("blocked_read_within_stop", int'(ack_cyc <= stop_cyc + CPB + 2), 1);

        // Five bytes, no reads: overrun on the fifth only
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, stop_cyc);
            repeat (4) @(negedge clk);
            if (i == 4) check_output("overrun_after_4", ovr_seen, exp_ovr);
        end
        check_output("overrun_after_5", ovr_seen, 1);
        check_output("overrun_model", ovr_seen, exp_ovr);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(DIR_READ, 8'h00, 20, got, ack_cyc);
            check_output("fifo_read_acked", int'(got), 1);
        end
        apply_stimulus(DIR_READ, 8'h00, 150, got, ack_cyc);
        check_output("fifth_read_blocks", int'(got), 0);
        apply_reset();

        // Frame error followed by a good byte
        send_byte(8'h99, 1'b0, stop_cyc);
        repeat (3 * CPB) @(negedge clk);
        check_output("frame_err_pulses", ferr_seen, 1);
        send_byte(8'h7E, 1'b1, stop_cyc);
        apply_stimulus(DIR_READ, 8'h00, 20, got, ack_cyc);
        check_output("after_frame_err_read", int'(got), 1);
        apply_stimulus(DIR_READ, 8'h00, 100, got, ack_cyc);
        check_output("frame_err_nothing_pushed", int'(got), 0);
        apply_reset();

        // Two-cycle glitch must not push a byte
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_byte(8'h5A, 1'b1, stop_cyc);
        apply_stimulus(DIR_READ, 8'h00, 20, got, ack_cyc);
        check_output("after_glitch_read", int'(got), 1);

        // Reset in the middle of a TX frame with a byte sitting in the FIFO
        send_byte(8'h11, 1'b1, stop_cyc);
        apply_stimulus(DIR_WRITE, 8'hC3, 20, got, ack_cyc);
        check_output("pre_reset_write_ack", int'(got), 1);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_ack.delete();
        exp_tx.delete();
        model_q.delete();
        pending_reads = 0;
        @(negedge clk);
        @(negedge clk);
        check_output("midframe_reset_uart_tx", int'(uart_tx), 1);
        check_output("midframe_reset_io_ack", int'(ifc.io_ack), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply_stimulus(DIR_READ, 8'h00, 100, got, ack_cyc);
        check_output("reset_fifo_empty", int'(got), 0);
        apply_reset();
        repeat (12 * CPB) @(negedge clk);

        // Randomised mix of writes, received bytes and non-blocking reads
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(2, 0))
                0: begin
                    b = 8'($urandom_range(255, 0));
                    apply_stimulus(DIR_WRITE, b, 200, got, ack_cyc);
                    check_output("rand_write_ack", int'(got), 1);
                end
                1: begin
                    b = 8'($urandom_range(255, 0));
                    send_byte(b, 1'b1, stop_cyc);
                    repeat ($urandom_range(6, 2)) @(negedge clk);
                end
                default: begin
                    if (model_q.size() > 0) begin
                        apply_stimulus(DIR_READ, 8'h00, 20, got, ack_cyc);
                        check_output("rand_read_ack", int'(got), 1);
                    end
                end
            endcase
        end

        repeat (12 * CPB) @(negedge clk);
        check_output("final_overrun_count", ovr_seen, exp_ovr);
        check_output("final_frame_err_count", ferr_seen, exp_ferr);
        check_output("final_acks_outstanding", exp_ack.size(), 0);
        check_output("final_tx_outstanding", exp_tx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
